// File: rtl/basilisk_sqrt_dispatcher_pkg.sv
// Shared types and constants for the sqrt dispatcher slice.
package basilisk_sqrt_dispatcher_pkg;

  localparam int unsigned BASILISK_SQRT_UNITS = 2;
  localparam int unsigned UNIT_INDEX_W = (BASILISK_SQRT_UNITS > 1) ? $clog2(BASILISK_SQRT_UNITS) : 1;
  localparam int unsigned IN_FLIGHT_W = 8;

  typedef logic [UNIT_INDEX_W-1:0] basilisk_sqrt_unit_index_t;
  typedef logic [IN_FLIGHT_W-1:0]  basilisk_in_flight_t;

  // Sqrt work item passed between the exponent, operation and rounding stages.
  typedef struct packed {
    logic        sign;
    logic [10:0] exponent;
    logic [52:0] mantissa;
    logic [2:0]  flags;
  } fpu_sqrt_result_t;

endpackage

// File: rtl/basilisk_sqrt_dispatcher_flow_stage.sv
// Valid/ready flow stage: MODE 0 is a wire, MODE 1 a full-throughput register.
module basilisk_sqrt_dispatcher_flow_stage
  import basilisk_sqrt_dispatcher_pkg::*;
#(
  parameter int unsigned MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fpu_sqrt_result_t in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output fpu_sqrt_result_t out_payload
);

  if (MODE == 0) begin : g_pass
    assign out_valid   = in_valid;
    assign out_payload = in_payload;
    assign in_ready    = out_ready;
  end else begin : g_reg
    logic             valid_q;
    fpu_sqrt_result_t payload_q;

    // Register accepts whenever empty or being drained this cycle.
    assign in_ready    = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;

    // Hold state; reset empties the stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
      end
    end

    // Payload only loads on a real transfer.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        payload_q <= in_payload;
      end
    end
  end

endmodule

// File: rtl/basilisk_sqrt_dispatcher.sv
// Round-robin issue of sqrt commands to parallel units with in-order retire.
module basilisk_sqrt_dispatcher
  import basilisk_sqrt_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_UNITS            = BASILISK_SQRT_UNITS,
  parameter int unsigned MAX_OUTSTANDING      = 2 * NUM_UNITS,
  parameter int unsigned OUTPUT_REGISTER_MODE = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sqrt_exponent_command_valid,
  output logic                                   sqrt_exponent_command_ready,
  input  fpu_sqrt_result_t                       sqrt_exponent_command_payload,
  output logic                                   sqrt_operation_command_valid,
  input  logic                                   sqrt_operation_command_ready,
  output fpu_sqrt_result_t                       sqrt_operation_command_payload,
  output logic             [NUM_UNITS-1:0]       unit_command_valid,
  input  logic             [NUM_UNITS-1:0]       unit_command_ready,
  output fpu_sqrt_result_t [NUM_UNITS-1:0]       unit_command_payload,
  input  logic             [NUM_UNITS-1:0]       unit_result_valid,
  output logic             [NUM_UNITS-1:0]       unit_result_ready,
  input  fpu_sqrt_result_t [NUM_UNITS-1:0]       unit_result_payload,
  output logic                                   busy
);

  localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_UNITS - 1);
  localparam basilisk_in_flight_t CAP = IN_FLIGHT_W'(MAX_OUTSTANDING);

  logic [PTR_W-1:0]    issue_ptr;
  logic [PTR_W-1:0]    retire_ptr;
  basilisk_in_flight_t in_flight;

  logic             below_cap;
  logic             active;
  logic             accept;
  logic             retire;
  logic             int_valid;
  logic             int_ready;
  fpu_sqrt_result_t int_payload;

  assign below_cap = in_flight < CAP;
  // Retire pointer only addresses an issued slot while something is in flight.
  assign active    = in_flight != '0;
  assign busy      = active;

  // Issue steering: broadcast payload, qualify only the lane at issue_ptr.
  always_comb begin
    unit_command_valid = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      unit_command_payload[i] = sqrt_exponent_command_payload;
    end
    unit_command_valid[issue_ptr] = sqrt_exponent_command_valid && below_cap;
    sqrt_exponent_command_ready   = unit_command_ready[issue_ptr] && below_cap;
  end

  // Retire steering: only the oldest outstanding unit may hand over its result.
  always_comb begin
    unit_result_ready             = '0;
    int_valid                     = unit_result_valid[retire_ptr] && active;
    int_payload                   = unit_result_payload[retire_ptr];
    unit_result_ready[retire_ptr] = int_ready && active;
  end

  assign accept = sqrt_exponent_command_valid && sqrt_exponent_command_ready;
  assign retire = int_valid && int_ready;

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_ptr  <= '0;
      retire_ptr <= '0;
      in_flight  <= '0;
    end else begin
      if (accept) begin
        issue_ptr <= (issue_ptr == LAST_PTR) ? '0 : issue_ptr + PTR_W'(1);
      end
      if (retire) begin
        retire_ptr <= (retire_ptr == LAST_PTR) ? '0 : retire_ptr + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   in_flight <= in_flight + IN_FLIGHT_W'(1);
        2'b01:   in_flight <= in_flight - IN_FLIGHT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  basilisk_sqrt_dispatcher_flow_stage #(
    .MODE(OUTPUT_REGISTER_MODE)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (int_valid),
    .in_ready   (int_ready),
    .in_payload (int_payload),
    .out_valid  (sqrt_operation_command_valid),
    .out_ready  (sqrt_operation_command_ready),
    .out_payload(sqrt_operation_command_payload)
  );

endmodule

// File: tb/tb_basilisk_sqrt_dispatcher.sv
// Scoreboard bench: unit models in the bench, expected results queued at issue.
module tb_basilisk_sqrt_dispatcher;
  import basilisk_sqrt_dispatcher_pkg::*;

  localparam int unsigned NU   = 2;
  localparam int unsigned MAXO = 3;
  localparam logic [67:0] XK   = 68'hA_5A5A_5A5A_5A5A_5A5A;
  localparam logic [67:0] VEC [0:11] = '{
    68'h0_0000_0000_0000_0001, 68'h1_2345_6789_ABCD_EF01, 68'hF_FFFF_FFFF_FFFF_FFFF,
    68'h8_0000_0000_0000_0000, 68'h3_C3C3_C3C3_C3C3_C3C3, 68'h7_0F0F_0F0F_0F0F_0F0F,
    68'h0_DEAD_BEEF_CAFE_F00D, 68'h5_5555_5555_5555_5555, 68'h2_0000_FFFF_0000_FFFF,
    68'h9_8765_4321_0FED_CBA9, 68'h4_1111_2222_3333_4444, 68'hE_0101_0101_0101_0101
  };

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  fpu_sqrt_result_t in_payload, out_payload;
  logic [NU-1:0] unit_command_valid, unit_command_ready, unit_result_valid, unit_result_ready;
  fpu_sqrt_result_t [NU-1:0] unit_command_payload, unit_result_payload;

  basilisk_sqrt_dispatcher #(
    .NUM_UNITS(NU), .MAX_OUTSTANDING(MAXO), .OUTPUT_REGISTER_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .sqrt_exponent_command_valid(in_valid), .sqrt_exponent_command_ready(in_ready),
    .sqrt_exponent_command_payload(in_payload),
    .sqrt_operation_command_valid(out_valid), .sqrt_operation_command_ready(out_ready),
    .sqrt_operation_command_payload(out_payload),
    .unit_command_valid(unit_command_valid), .unit_command_ready(unit_command_ready),
    .unit_command_payload(unit_command_payload),
    .unit_result_valid(unit_result_valid), .unit_result_ready(unit_result_ready),
    .unit_result_payload(unit_result_payload),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_out   = 0;
  int exp_lane = 0;
  int in_cyc [$];
  int out_cyc [$];
  logic [67:0] sbq [$];

  fpu_sqrt_result_t uq [NU][$];
  int udone [NU][$];
  int ulat [NU];

  logic [NU-1:0] cmd_fire_l = '0;
  logic [NU-1:0] res_fire_l = '0;
  fpu_sqrt_result_t cmd_pay_l;
  logic rst_l = 1'b1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: record handshakes, push expectations on issue, pop/compare on output.
  always @(negedge clk) begin
    logic [NU-1:0] oh;
    rst_l      = rst;
    cmd_fire_l = unit_command_valid & unit_command_ready;
    res_fire_l = unit_result_valid & unit_result_ready;
    cmd_pay_l  = in_payload;
    if (rst) begin
      sbq.delete();
      exp_lane = 0;
    end else begin
      if (in_valid && in_ready) begin
        n_acc++;
        in_cyc.push_back(cyc);
        sbq.push_back(68'(in_payload) ^ XK);
        oh = '0;
        oh[exp_lane] = 1'b1;
        chk("issue_lane", 68'(cmd_fire_l), 68'(oh));
        chk("issue_payload", 68'(unit_command_payload[exp_lane]), 68'(in_payload));
        exp_lane = (exp_lane + 1) % NU;
      end
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sbq.size() == 0) chk("unexpected_output", 68'(out_payload), 68'h0);
        else chk("output_payload", 68'(out_payload), sbq.pop_front());
      end
    end
  end

  // Unit models: two-deep queue each, result valid ulat cycles after acceptance.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int u = 0; u < NU; u++) begin
      if (rst_l) begin
        uq[u].delete();
        udone[u].delete();
      end else begin
        if (res_fire_l[u] && uq[u].size() > 0) begin
          void'(uq[u].pop_front());
          void'(udone[u].pop_front());
        end
        if (cmd_fire_l[u]) begin
          uq[u].push_back(fpu_sqrt_result_t'(68'(cmd_pay_l) ^ XK));
          udone[u].push_back(cyc + ulat[u]);
        end
      end
      unit_command_ready[u]  = uq[u].size() < 2;
      unit_result_valid[u]   = (uq[u].size() > 0) && (cyc >= udone[u][0]);
      unit_result_payload[u] = (uq[u].size() > 0) ? uq[u][0] : '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [67:0] p);
    int t;
    t = 0;
    in_valid   = 1'b1;
    in_payload = fpu_sqrt_result_t'(p);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 68'(t), 68'h0);
        break;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("output_count", 68'(n_out), 68'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, cnt_rdy, cnt_rr, t;
    rst = 1'b1; in_valid = 1'b0; in_payload = '0; out_ready = 1'b1;
    ulat[0] = 27; ulat[1] = 27;
    unit_command_ready = '0; unit_result_valid = '0; unit_result_payload = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 68'(busy), 68'h0);
    chk("reset_out_valid", 68'(out_valid), 68'h0);
    chk("reset_unit_cmd_valid", 68'(unit_command_valid), 68'h0);
    chk("reset_unit_res_ready", 68'(unit_result_ready), 68'h0);
    chk("reset_in_ready", 68'(in_ready), 68'h1);
    step();

    // Single command: unit latency 27 plus one output register stage.
    send(VEC[0]);
    wait_outs(1);
    chk("single_latency", 68'(out_cyc[0] - in_cyc[0]), 68'd29);
    @(negedge clk);
    chk("single_busy_clear", 68'(busy), 68'h0);
    step();

    // Three back-to-back commands alternate lanes and come out in order.
    send(VEC[1]); send(VEC[2]); send(VEC[3]);
    chk("b2b_issue_gap1", 68'(in_cyc[2] - in_cyc[1]), 68'd1);
    chk("b2b_issue_gap2", 68'(in_cyc[3] - in_cyc[2]), 68'd1);
    wait_outs(4);
    repeat (3) step();

    // Unit1 finishes 5 cycles before unit0; output waits for the older one.
    ulat[0] = 33; ulat[1] = 27;
    send(VEC[4]); send(VEC[5]);
    wait_outs(6);
    chk("ooo_first_latency", 68'(out_cyc[4] - in_cyc[4]), 68'd35);
    chk("ooo_back_to_back", 68'(out_cyc[5] - out_cyc[4]), 68'd1);
    ulat[0] = 3; ulat[1] = 3;
    repeat (3) step();

    // Occupancy cap with a stalled output.
    out_ready = 1'b0;
    base = n_acc;
    send(VEC[6]); send(VEC[7]); send(VEC[8]); send(VEC[9]);
    in_valid = 1'b1; in_payload = fpu_sqrt_result_t'(VEC[10]);
    cnt_rdy = 0; cnt_rr = 0;
    repeat (50) begin
      @(negedge clk);
      if (in_ready) cnt_rdy++;
      if (unit_result_ready != '0) cnt_rr++;
    end
    chk("cap_in_ready_low", 68'(cnt_rdy), 68'h0);
    chk("stall_unit_res_ready_low", 68'(cnt_rr), 68'h0);
    chk("cap_accept_count", 68'(n_acc - base), 68'd4);
    chk("stall_out_held", 68'(out_valid), 68'h1);
    chk("stall_busy", 68'(busy), 68'h1);
    step();
    out_ready = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready || t > 100) break;
      t++;
    end
    chk("cap_release_accept", 68'(in_ready), 68'h1);
    step();
    in_valid = 1'b0;
    wait_outs(11);
    repeat (3) step();

    // Reset with work in flight discards everything.
    ulat[0] = 40; ulat[1] = 40;
    send(VEC[11]); send(VEC[0]); send(VEC[1]);
    @(negedge clk);
    chk("pre_reset_busy", 68'(busy), 68'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 68'(busy), 68'h0);
    chk("post_reset_out_valid", 68'(out_valid), 68'h0);
    chk("post_reset_unit_res_ready", 68'(unit_result_ready), 68'h0);
    base = n_out;
    repeat (60) step();
    chk("no_stale_output", 68'(n_out), 68'(base));
    ulat[0] = 27; ulat[1] = 27;
    send(VEC[2]);
    wait_outs(base + 1);
    repeat (3) step();
    chk("scoreboard_empty", 68'(sbq.size()), 68'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
